// File: rtl/alu_exec_stage.sv
// Registered LEGv8 execute-stage ALU with valid/ready handshakes on both sides.
// Optional iterative shift-add multiplier for opcode 1000 is enabled by defining ALU_EXEC_MUL_EN.
module alu_exec_stage #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   alucontrol,
  input  logic [N-1:0] srca,
  input  logic [N-1:0] srcb,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         zero
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_PASS = 4'b0111;

`ifdef ALU_EXEC_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam int         CNT_W   = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;
`else
  typedef enum logic {S_IDLE, S_HOLD} state_t;
`endif

  state_t       state_q, state_d;
  logic [N-1:0] result_q, result_d;
  logic         zero_q, zero_d;
  logic         accept;
  logic [N-1:0] single_res;

`ifdef ALU_EXEC_MUL_EN
  logic [N-1:0]     mcand_q, mcand_d;
  logic [N-1:0]     mplier_q, mplier_d;
  logic [N-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     acc_step;
`endif

  function automatic logic [N-1:0] alu_single(input logic [3:0]   op,
                                                input logic [N-1:0] a,
                                                input logic [N-1:0] b);
    logic [N-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_PASS: r = b;
      default: r = '0;
    endcase
    return r;
  endfunction

  // in_ready depends only on state and out_ready, never on in_valid
  always_comb begin
`ifdef ALU_EXEC_MUL_EN
    in_ready = (state_q == S_IDLE) | ((state_q == S_HOLD) & out_ready);
`else
    in_ready = (state_q == S_IDLE) | out_ready;
`endif
    accept     = in_valid & in_ready;
    single_res = alu_single(alucontrol, srca, srcb);
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
`ifdef ALU_EXEC_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif
    case (state_q)
      S_IDLE, S_HOLD: begin
        if (accept) begin
`ifdef ALU_EXEC_MUL_EN
          if (alucontrol == OP_MUL) begin
            mcand_d  = srca;
            mplier_d = srcb;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = S_MUL;
          end else begin
            result_d = single_res;
            zero_d   = (single_res == '0);
            state_d  = S_HOLD;
          end
`else
          result_d = single_res;
          zero_d   = (single_res == '0);
          state_d  = S_HOLD;
`endif
        end else if ((state_q == S_HOLD) && out_ready) begin
          state_d = S_IDLE;
        end
      end
`ifdef ALU_EXEC_MUL_EN
      // One shift-add step per edge; the last step lands directly in result
      S_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(N - 1)) begin
          result_d = acc_step;
          zero_d   = (acc_step == '0);
          state_d  = S_HOLD;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
`ifdef ALU_EXEC_MUL_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign out_valid = (state_q == S_HOLD);
  assign result    = result_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Randomised scoreboard bench for alu_exec_stage with directed handshake/latency checks.
// Expected results come from a plain arithmetic reference model keyed on the opcode.
module tb_alu_exec_stage;
  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   alucontrol;
  logic [N-1:0] srca;
  logic [N-1:0] srcb;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic         zero;

  int checks = 0;
  int errors = 0;
  logic [N-1:0] sb_q[$];

  always #5 clk = ~clk;

  alu_exec_stage #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alucontrol (alucontrol),
    .srca       (srca),
    .srcb       (srcb),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero)
  );

  function automatic logic [N-1:0] ref_model(input logic [3:0] op,
                                             input logic [N-1:0] a,
                                             input logic [N-1:0] b);
    case (op)
      4'h0: return a & b;
      4'h1: return a | b;
      4'h2: return a + b;
      4'h6: return a - b;
      4'h7: return b;
`ifdef ALU_EXEC_MUL_EN
      4'h8: return a * b;
`endif
      default: return '0;
    endcase
  endfunction

  task automatic check_output(input string name, input logic [N-1:0] actual,
                              input logic [N-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Drive one cycle's inputs after the falling edge; record the op if it will be accepted
  task automatic apply_stimulus(input logic v, input logic [3:0] op,
                                input logic [N-1:0] a, input logic [N-1:0] b,
                                input logic ordy);
    @(negedge clk);
    in_valid   = v;
    alucontrol = op;
    srca       = a;
    srcb       = b;
    out_ready  = ordy;
    #1;
    if (v && in_ready && !reset) sb_q.push_back(ref_model(op, a, b));
  endtask

  task automatic idle_cycle();
    apply_stimulus(1'b0, 4'h0, '0, '0, 1'b1);
  endtask

  // Monitor: every handshake on the output side pops one expected result
  initial begin
    int idle;
    logic [N-1:0] exp_r;
    idle = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb_unexpected: got result %0h expected no output", result);
        end else begin
          exp_r = sb_q.pop_front();
          check_output("sb_result", result, exp_r);
          check_output("sb_zero", N'(zero), N'(exp_r == '0));
        end
        idle = 0;
      end else if (sb_q.size() != 0) begin
        idle++;
        if (idle > 4 * N + 50) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb_timeout: got no output after %0d cycles expected %0d pending", idle, sb_q.size());
          sb_q.delete();
          idle = 0;
        end
      end else begin
        idle = 0;
      end
    end
  end

  initial begin
    logic [3:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         any_valid;

    reset      = 1'b1;
    in_valid   = 1'b0;
    alucontrol = '0;
    srca       = '0;
    srcb       = '0;
    out_ready  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_output("rst_out_valid", N'(out_valid), '0);
    check_output("rst_result", result, '0);
    check_output("rst_zero", N'(zero), '0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_output("rst_in_ready", N'(in_ready), N'(1));

    // ADD 5+7, one-cycle latency, then output drops
    apply_stimulus(1'b1, 4'h2, 64'd5, 64'd7, 1'b1);
    check_output("add_out_valid_pre", N'(out_valid), '0);
    idle_cycle();
    check_output("add_out_valid", N'(out_valid), N'(1));
    check_output("add_result", result, 64'd12);
    check_output("add_zero", N'(zero), '0);
    idle_cycle();
    check_output("add_out_valid_drop", N'(out_valid), '0);

    // SUB, CBZ, AND back to back
    apply_stimulus(1'b1, 4'h6, 64'd9, 64'd9, 1'b1);
    check_output("b2b_in_ready0", N'(in_ready), N'(1));
    apply_stimulus(1'b1, 4'h7, 64'd123, 64'd0, 1'b1);
    check_output("b2b_in_ready1", N'(in_ready), N'(1));
    check_output("b2b_valid1", N'(out_valid), N'(1));
    check_output("b2b_zero1", N'(zero), N'(1));
    apply_stimulus(1'b1, 4'h0, 64'hF0, 64'h0F, 1'b1);
    check_output("b2b_in_ready2", N'(in_ready), N'(1));
    check_output("b2b_valid2", N'(out_valid), N'(1));
    check_output("b2b_zero2", N'(zero), N'(1));
    idle_cycle();
    check_output("b2b_valid3", N'(out_valid), N'(1));
    check_output("b2b_result3", result, '0);
    check_output("b2b_zero3", N'(zero), N'(1));

    // Wraparound ADD and OR
    apply_stimulus(1'b1, 4'h2, {N{1'b1}}, 64'd1, 1'b1);
    apply_stimulus(1'b1, 4'h1, 64'hA0, 64'h05, 1'b1);
    check_output("wrap_result", result, '0);
    check_output("wrap_zero", N'(zero), N'(1));
    idle_cycle();
    check_output("or_result", result, 64'hA5);
    idle_cycle();

    // Output stall holds the result and blocks the next op
    apply_stimulus(1'b1, 4'h2, 64'd3, 64'd4, 1'b0);
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(1'b1, 4'h6, 64'd10, 64'd1, 1'b0);
      check_output("stall_in_ready", N'(in_ready), '0);
      check_output("stall_result", result, 64'd7);
    end
    apply_stimulus(1'b1, 4'h6, 64'd10, 64'd1, 1'b1);
    check_output("unstall_in_ready", N'(in_ready), N'(1));
    idle_cycle();
    check_output("unstall_result", result, 64'd9);
    idle_cycle();

`ifdef ALU_EXEC_MUL_EN
    apply_stimulus(1'b1, 4'h8, 64'd6, 64'd7, 1'b1);
    for (int k = 1; k <= N; k++) begin
      idle_cycle();
      check_output("mul_in_ready", N'(in_ready), '0);
      if (k == N) check_output("mul_valid_early", N'(out_valid), '0);
    end
    idle_cycle();
    check_output("mul_valid", N'(out_valid), N'(1));
    check_output("mul_result", result, 64'd42);

    a = '0;
    a[N-1] = 1'b1;
    apply_stimulus(1'b1, 4'h8, a, 64'd2, 1'b1);
    repeat (N) idle_cycle();
    idle_cycle();
    check_output("mul_wrap_result", result, '0);
    check_output("mul_wrap_zero", N'(zero), N'(1));

    // Reset during iteration aborts the multiply
    apply_stimulus(1'b1, 4'h8, 64'd6, 64'd7, 1'b1);
    repeat (10) idle_cycle();
    @(negedge clk);
    reset = 1'b1;
    sb_q.delete();
    #1;
    check_output("mul_abort_valid", N'(out_valid), '0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_output("mul_abort_in_ready", N'(in_ready), N'(1));
    any_valid = 1'b0;
    repeat (N + 4) begin
      idle_cycle();
      if (out_valid) any_valid = 1'b1;
    end
    check_output("mul_abort_no_output", N'(any_valid), '0);
`else
    apply_stimulus(1'b1, 4'h8, 64'd6, 64'd7, 1'b1);
    idle_cycle();
    check_output("op8_valid", N'(out_valid), N'(1));
    check_output("op8_result", result, '0);
    check_output("op8_zero", N'(zero), N'(1));
    idle_cycle();
`endif

    // Random traffic with random back-pressure
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 7))
        0: op = 4'h0;
        1: op = 4'h1;
        2: op = 4'h2;
        3: op = 4'h6;
        4: op = 4'h7;
        5: op = 4'h8;
        6: op = 4'($urandom_range(0, 15));
        default: op = 4'h2;
      endcase
      if ($urandom_range(0, 3) == 0) a = N'($urandom_range(0, 3));
      else a = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) b = N'($urandom_range(0, 3));
      else b = {$urandom, $urandom};
      apply_stimulus($urandom_range(0, 9) < 7, op, a, b, $urandom_range(0, 9) < 7);
    end

    repeat (4 * N + 60) idle_cycle();
    check_output("drain_empty", N'(sb_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
